// File: rtl/conv_channel_pipe_if.sv
// conv_channel_pipe_if: beat input and result output handshakes of one convolution channel
//   in_valid/in_ready   beat handshake, accepted when both high
//   in_data/in_weight   TAPS packed activations/weights, tap k at [k*DW +: DW]
//   out_valid/out_ready result handshake, consumed when both high
//   out_data            saturated DW-bit result
interface conv_channel_pipe_if #(parameter int DW = 16, parameter int TAPS = 9);
  logic in_valid, in_ready;
  logic [TAPS*DW-1:0] in_data, in_weight;
  logic out_valid, out_ready;
  logic [DW-1:0] out_data;
  modport master (output in_valid, in_data, in_weight, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, in_weight, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/conv_channel_pipe.sv
// conv_channel_pipe: multi-pass dot-product accumulator with bias, pool scaling, rounding, saturation and ReLU
//   clk, rst_n       clock, asynchronous active-low reset
//   clr              synchronous flush of pipeline, counters and output register
//   cfg_passes       beats per result (0 acts as 1), latched at a group's first beat
//   cfg_shift        pool scaling 0/2/4 extra right shifts, sampled in FIN
//   cfg_bias_en/bias bias added at finalisation, sampled in FIN
//   cfg_relu         clamp negative results to zero, sampled in FIN
//   io               beat input and result output handshakes
//   acc_snoop        raw accumulator >>> FRAC, saturated to DW
//   busy             high whenever the FSM is not idle
module conv_channel_pipe #(
  parameter int DW = 16,
  parameter int TAPS = 9,
  parameter int FRAC = 8,
  parameter int ACC_W = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic [7:0] cfg_passes,
  input  logic [1:0] cfg_shift,
  input  logic cfg_bias_en,
  input  logic cfg_relu,
  input  logic signed [DW-1:0] bias,
  conv_channel_pipe_if.slave io,
  output logic signed [DW-1:0] acc_snoop,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, ACC, DRAIN, FIN, OUT} state_t;
  localparam int VW = ACC_W + 2;
  localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};
  state_t state;
  logic beat, s1_v, s1_first, s2_v, s2_first;
  logic [7:0] eff, npass, pcnt;
  logic [1:0] dcnt;
  logic [2:0] sh;
  logic signed [2*DW-1:0] prod [TAPS];
  logic signed [ACC_W-1:0] sum, s2_sum, acc, acc_nx, acc_fr;
  logic [ACC_W:0] acc_add;
  logic signed [VW-1:0] v, r;
  logic signed [DW-1:0] res;
  assign beat = io.in_valid && io.in_ready;
  assign busy = state != IDLE;
  always_comb begin
    eff = cfg_passes == 8'd0 ? 8'd1 : cfg_passes;
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(prod[k]);
    // the first beat of a group restarts the sum instead of adding to the previous result
    acc_add = (s2_first ? '0 : {acc[ACC_W-1], acc}) + {s2_sum[ACC_W-1], s2_sum};
    acc_nx = acc_add[ACC_W] != acc_add[ACC_W-1] ? (acc_add[ACC_W] ? AMIN : AMAX) : acc_add[ACC_W-1:0];
    acc_fr = acc >>> FRAC;
    acc_snoop = acc_fr > ACC_W'(DMAX) ? DMAX : acc_fr < ACC_W'(DMIN) ? DMIN : acc_fr[DW-1:0];
    sh = cfg_shift == 2'b00 ? 3'd0 : cfg_shift == 2'b01 ? 3'd2 : 3'd4;
    v = VW'(acc) + (cfg_bias_en ? VW'(bias) <<< FRAC : VW'(0));
    r = (v + (VW'(1) <<< (FRAC - 1 + sh))) >>> (FRAC + sh);
    res = cfg_relu && r < 0 ? '0 : r > VW'(DMAX) ? DMAX : r < VW'(DMIN) ? DMIN : r[DW-1:0];
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < TAPS; k++)
      prod[k] <= $signed(io.in_data[k*DW +: DW]) * $signed(io.in_weight[k*DW +: DW]);
    s2_sum <= sum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_first <= 1'b0;
      s2_v <= 1'b0;
      s2_first <= 1'b0;
      acc <= '0;
    end else begin
      s1_v <= beat && !clr;
      s1_first <= beat && state == IDLE && !clr;
      s2_v <= s1_v && !clr;
      s2_first <= s1_first && !clr;
      acc <= clr ? '0 : s2_v ? acc_nx : acc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      io.in_ready <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_data <= '0;
      npass <= '0;
      pcnt <= '0;
      dcnt <= '0;
    end else if (clr) begin
      state <= IDLE;
      io.in_ready <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_data <= '0;
      npass <= '0;
      pcnt <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          io.in_ready <= 1'b1;
          if (beat) begin
            npass <= eff;
            pcnt <= 8'd1;
            state <= eff == 8'd1 ? DRAIN : ACC;
            io.in_ready <= eff != 8'd1;
          end
        end
        ACC: if (beat) begin
          pcnt <= pcnt + 8'd1;
          if (pcnt + 8'd1 == npass) begin
            state <= DRAIN;
            io.in_ready <= 1'b0;
          end
        end
        // three cycles let the last beat pass S1, S2 and the accumulator
        DRAIN: begin
          dcnt <= dcnt == 2'd2 ? 2'd0 : dcnt + 2'd1;
          if (dcnt == 2'd2) state <= FIN;
        end
        FIN: begin
          io.out_data <= res;
          io.out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (io.out_ready) begin
          io.out_valid <= 1'b0;
          io.in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_channel_pipe.sv
// tb_conv_channel_pipe: directed and random scoreboard checks of conv_channel_pipe
module tb_conv_channel_pipe;
  localparam int DW = 16, TAPS = 9, FRAC = 8;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [7:0] cfg_passes;
  logic [1:0] cfg_shift;
  logic cfg_bias_en, cfg_relu;
  logic signed [DW-1:0] bias;
  logic signed [DW-1:0] acc_snoop;
  logic busy;
  int cyc = 0, total = 0, bad = 0, nxfer = 0, nexp = 0, t_acc = 0;
  int q[$];
  conv_channel_pipe_if #(.DW(DW), .TAPS(TAPS)) io ();
  conv_channel_pipe #(.DW(DW), .TAPS(TAPS), .FRAC(FRAC), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_passes(cfg_passes), .cfg_shift(cfg_shift),
    .cfg_bias_en(cfg_bias_en), .cfg_relu(cfg_relu), .bias(bias), .io(io),
    .acc_snoop(acc_snoop), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (io.out_valid && io.out_ready) nxfer <= nxfer + 1;
  end
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic [TAPS*DW-1:0] fill(input logic [DW-1:0] x);
    logic [TAPS*DW-1:0] p;
    for (int k = 0; k < TAPS; k++) p[k*DW +: DW] = x;
    return p;
  endfunction
  function automatic logic [TAPS*DW-1:0] one(input logic [DW-1:0] x);
    logic [TAPS*DW-1:0] p;
    p = '0;
    p[DW-1:0] = x;
    return p;
  endfunction
  function automatic longint dot(input logic [TAPS*DW-1:0] d, input logic [TAPS*DW-1:0] w);
    longint s = 0;
    for (int k = 0; k < TAPS; k++)
      s += longint'($signed(d[k*DW +: DW])) * longint'($signed(w[k*DW +: DW]));
    return s;
  endfunction
  function automatic int fin(input longint acc, input int shift, input bit be, input int b, input bit relu);
    longint vv, rr;
    int s;
    vv = acc + (be ? longint'(b) * (longint'(1) << FRAC) : 0);
    s = FRAC + (shift == 0 ? 0 : shift == 1 ? 2 : 4);
    rr = (vv + (longint'(1) << (s - 1))) >>> s;
    if (rr > 32767) rr = 32767;
    if (rr < -32768) rr = -32768;
    if (relu && rr < 0) rr = 0;
    return int'(rr);
  endfunction
  task automatic cfg(input int p, input int sh, input bit be, input int b, input bit rl);
    cfg_passes = 8'(p);
    cfg_shift = 2'(sh);
    cfg_bias_en = be;
    bias = 16'(b);
    cfg_relu = rl;
  endtask
  task automatic send(input logic [TAPS*DW-1:0] d, input logic [TAPS*DW-1:0] w);
    int n = 0;
    io.in_valid = 1'b1;
    io.in_data = d;
    io.in_weight = w;
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", io.in_ready, 1);
    t_acc = cyc;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!io.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic expect_out(input string tag);
    int e;
    wait_valid();
    chk({tag, "_vld"}, io.out_valid, 1);
    chk({tag, "_lat"}, cyc - t_acc, 5);
    e = q.size() != 0 ? q.pop_front() : 32'h7fffffff;
    chk({tag, "_dat"}, $signed(io.out_data), e);
    nexp++;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [TAPS*DW-1:0] d, w;
    longint acc;
    int e, p, sh, b, x;
    bit be, rl;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.in_weight = '0;
    io.out_ready = 1'b1;
    cfg(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", io.in_ready, 0);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_data", io.out_data, 0);
    chk("rst_snoop", acc_snoop, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", io.in_ready, 1);
    q.push_back(2304); send(fill(256), fill(256)); expect_out("basic");
    chk("basic_snoop", acc_snoop, 2304);
    cfg(1, 1, 0, 0, 0); q.push_back(576); send(fill(256), fill(256)); expect_out("shift1");
    cfg(1, 2, 0, 0, 0); q.push_back(144); send(fill(256), fill(256)); expect_out("shift2");
    cfg(1, 3, 0, 0, 0); q.push_back(144); send(fill(256), fill(256)); expect_out("shift3");
    cfg(1, 0, 1, 256, 0); q.push_back(2560); send(fill(256), fill(256)); expect_out("bias");
    cfg(0, 0, 0, 0, 0); q.push_back(2304); send(fill(256), fill(256)); expect_out("pass0");
    cfg(4, 0, 0, 0, 0); q.push_back(32767);
    repeat (4) send(fill(16'h7fff), fill(16'h7fff));
    expect_out("sat_pos");
    q.push_back(-32768);
    repeat (4) send(fill(16'h7fff), fill(16'h8000));
    expect_out("sat_neg");
    cfg(4, 0, 0, 0, 1); q.push_back(0);
    repeat (4) send(fill(16'h7fff), fill(16'h8000));
    expect_out("relu");
    cfg(1, 0, 0, 0, 0);
    q.push_back(1); send(one(16'd1), one(16'd128)); expect_out("rnd_half");
    q.push_back(0); send(one(16'd1), one(-16'sd128)); expect_out("rnd_neg_half");
    q.push_back(2); send(one(16'd1), one(16'd384)); expect_out("rnd_1p5");
    q.push_back(-1); send(one(16'd1), one(-16'sd384)); expect_out("rnd_m1p5");
    io.out_ready = 1'b0;
    send(fill(256), fill(256));
    wait_valid();
    chk("bp_vld", io.out_valid, 1);
    chk("bp_lat", cyc - t_acc, 5);
    chk("bp_dat", $signed(io.out_data), 2304);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_dat", $signed(io.out_data), 2304);
      chk("bp_hold_vld", io.out_valid, 1);
      chk("bp_hold_rdy", io.in_ready, 0);
      chk("bp_hold_busy", busy, 1);
    end
    io.out_ready = 1'b1;
    nexp++;
    @(negedge clk);
    chk("bp_rel_vld", io.out_valid, 0);
    chk("bp_rel_busy", busy, 0);
    chk("bp_rel_rdy", io.in_ready, 1);
    cfg(3, 0, 0, 0, 0);
    repeat (3) send(fill(256), fill(256));
    chk("clr_in_drain", busy, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_vld", io.out_valid, 0);
    chk("clr_snoop", acc_snoop, 0);
    chk("clr_rdy", io.in_ready, 1);
    cfg(1, 0, 0, 0, 0); q.push_back(2304); send(fill(256), fill(256)); expect_out("after_clr");
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(1, 3);
      sh = $urandom_range(0, 3);
      be = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 1));
      b = int'($urandom_range(0, 4095)) - 2048;
      cfg(p, sh, be, b, rl);
      acc = 0;
      for (int j = 0; j < p; j++) begin
        for (int k = 0; k < TAPS; k++) begin
          x = int'($urandom_range(0, 1023)) - 512;
          d[k*DW +: DW] = x[DW-1:0];
          x = int'($urandom_range(0, 1023)) - 512;
          w[k*DW +: DW] = x[DW-1:0];
        end
        acc += dot(d, w);
        send(d, w);
      end
      q.push_back(fin(acc, sh, be, b, rl));
      expect_out("rand");
    end
    cfg(4, 0, 0, 0, 0);
    repeat (2) send(fill(256), fill(256));
    repeat (3) @(negedge clk);
    chk("mid_snoop", acc_snoop, 4608);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_snoop", acc_snoop, 0);
    chk("arst_vld", io.out_valid, 0);
    chk("arst_rdy", io.in_ready, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_rdy", io.in_ready, 1);
    repeat (8) @(negedge clk);
    chk("xfers", nxfer, nexp);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_channel_pipe.md
Name: conv_channel_pipe

Overview:
Parametrised convolution channel for the ShuffleNet datapath. Each input beat carries TAPS activation/weight pairs. The block reduces each beat to one dot product and accumulates cfg_passes beats, one per input channel. It then applies bias, average-pool scaling, rounding, saturation and optional ReLU, and emits one DW-bit result through a valid/ready handshake. Instances sit in parallel per output channel between the line buffer and the feature-map writer.

Parameters:
DW, 16, activation/weight/output width (signed, two's complement)
TAPS, 9, products per beat (3x3 kernel)
FRAC, 8, fractional bits of activations and weights (Q(DW-FRAC).FRAC)
ACC_W, 48, accumulator width; must be >= 2*DW+clog2(TAPS)+8

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
clr  in  1  synchronous flush of pipeline, counters and output register
cfg_passes  in  8  beats per result; 0 is treated as 1; sampled at the first beat of a group
cfg_shift  in  2  pool scaling: 00 none, 01 >>>2 (2x2 avg), 10 >>>4 (4x4 avg), 11 same as 10
cfg_bias_en  in  1  add bias at finalisation
cfg_relu  in  1  clamp negative results to 0
bias  in  DW  signed bias in the same Q format as the output; sampled at finalisation
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid&&in_ready
in_data  in  TAPS*DW  activations, tap k at bits [k*DW +: DW]
in_weight  in  TAPS*DW  weights, same packing
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&&out_ready
out_data  out  DW  saturated result
acc_snoop  out  DW  raw accumulator >>> FRAC, saturated to DW, no bias/shift/relu (debug/buffer tap)
busy  out  1  state != IDLE

Behaviour:
- Reset (RST_N=0, async): state IDLE; in_ready=0 during reset, 1 in IDLE after release; out_valid=0; out_data=0; acc_snoop=0; all pipeline valids, pass counter and accumulator cleared.
- FSM: IDLE -> ACC on first accepted beat. ACC -> DRAIN when the accepted beat is pass number cfg_passes. DRAIN (3 cycles, in_ready=0) -> FIN. FIN (1 cycle, result computed into output register) -> OUT. OUT -> IDLE on out_valid&&out_ready.
- in_ready=1 only in IDLE and ACC. Beats are never dropped.
- Pipeline:
  - S1 registers the TAPS full-precision 2*DW products.
  - S2 registers their sign-extended sum.
  - S3 adds it to the accumulator. The accumulator is zeroed at group start and saturates at ACC_W signed limits rather than wrapping.
- Latency: last beat accepted at cycle T -> out_valid high at T+5. Single-pass throughput is one result per 6 cycles, plus any time out_ready is held low.
- Finalisation, at full precision:
  - v = acc + (cfg_bias_en ? bias<<<FRAC : 0).
  - s = FRAC + {0,2,4}[cfg_shift].
  - Round half-up: r = (v + (1<<<(s-1))) >>> s.
  - Saturate r to [-(2^(DW-1)), 2^(DW-1)-1].
  - If cfg_relu and r<0, r=0.
- out_data and out_valid are stable while out_valid&&!out_ready.
- acc_snoop updates every cycle the accumulator changes and holds otherwise.
- clr: takes effect next edge, has priority over every handshake in the same cycle. Result: state IDLE, out_valid=0, counters and accumulator zeroed, in-flight beats discarded.
- cfg_passes/cfg_shift changes mid-group: pass count uses the value latched at the group's first beat. cfg_shift, cfg_relu, cfg_bias_en and bias are sampled in FIN.
- in_valid during DRAIN/FIN/OUT is not accepted; the upstream stage holds the beat.

Test Plan:
- DW=16, FRAC=8, passes=1, all 9 taps in=256, w=256, shift=00, no bias/relu -> out_data=2304 exactly 5 cycles after accept; acc_snoop=2304.
- Same data, shift=01 -> 576. shift=10 -> 144. cfg_bias_en=1, bias=256, shift=00 -> 2560.
- passes=4, all in=32767, w=32767 -> out_data=32767 (saturate). All w=-32768 -> -32768. Add cfg_relu=1 -> 0.
- Rounding, passes=1, one tap in=1, w=128, others 0:
  - shift=00: sum 128 -> out 1 (half-up).
  - w=-128 -> out 0.
  - in=1, w=384 -> out 2 (384/256 = 1.5 rounds to 2).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, busy=1. Release -> one transfer, IDLE next cycle, in_ready=1.
- Assert clr during DRAIN of a passes=3 group, then run a passes=1 group of 2304 data -> only one result, 2304. Assert RST_N=0 mid-ACC -> out_valid, acc_snoop = 0 immediately, without waiting for a clock edge.
